// File: rtl/udp_rx.sv
// udp_rx: UDP receive stage behind the IPv4 RX filter.
// Parses the 8-byte UDP header, filters on destination port and length, and
// forwards the payload with zero latency (outputs are combinational).
// Optional build macro: UDP_RX_LEN_CHECK_EN -- cancel the payload when the
// received byte count disagrees with the UDP length field.
module udp_rx #(
   parameter int unsigned DATA_W     = 16,
   parameter logic [15:0] PORT       = 16'd18,
   parameter bit          MATCH_PORT = 1'b1,
   localparam int unsigned LEN_W     = $clog2(DATA_W/8+1)
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              cancel_i,
   input  logic              valid_i,
   input  logic              start_i,
   input  logic              term_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              cs_err_i,
   output logic              valid_o,
   output logic              start_o,
   output logic              term_o,
   output logic              cancel_o,
   output logic [DATA_W-1:0] data_o,
   output logic [LEN_W-1:0]  len_o,
   output logic [15:0]       src_port_o
);

   localparam int unsigned CNT_W   = 16;
   localparam logic [15:0] HDR_LEN = 16'd8;

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      HEAD = 4'b0010,
      DATA = 4'b0100,
      DROP = 4'b1000
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         word_q, word_d;
   logic [15:0]        src_q, src_d;
   logic [CNT_W-1:0]   pay_q, pay_d;
   logic [CNT_W-1:0]   pay_sum;
   logic [15:0]        field;
`ifdef UDP_RX_LEN_CHECK_EN
   logic [15:0]        len_q, len_d;
`endif

   // header fields arrive in network order: wire byte 0 is the MSB
   assign field      = {data_i[7:0], data_i[15:8]};
   assign pay_sum    = pay_q + CNT_W'(len_i);
   assign data_o     = data_i;
   assign len_o      = len_i;
   assign src_port_o = src_q;

   // state and header registers
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q <= IDLE;
         word_q  <= '0;
         src_q   <= '0;
         pay_q   <= '0;
`ifdef UDP_RX_LEN_CHECK_EN
         len_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         src_q   <= src_d;
         pay_q   <= pay_d;
`ifdef UDP_RX_LEN_CHECK_EN
         len_q   <= len_d;
`endif
      end
   end

   // next-state and combinational payload framing
   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      src_d    = src_q;
      pay_d    = pay_q;
`ifdef UDP_RX_LEN_CHECK_EN
      len_d    = len_q;
`endif
      valid_o  = 1'b0;
      start_o  = 1'b0;
      term_o   = 1'b0;
      cancel_o = 1'b0;

      if (valid_i) begin
         if (start_i) begin
            // a start word always restarts parsing; abort any payload in flight
            state_d  = cs_err_i ? DROP : HEAD;
            word_d   = 2'd1;
            src_d    = field;
            pay_d    = '0;
            cancel_o = (state_q == DATA);
            if (term_i) state_d = IDLE;
         end else begin
            unique case (state_q)
               HEAD: begin
                  word_d = word_q + 2'd1;
                  case (word_q)
                     2'd1: begin
                        if (MATCH_PORT && (field != PORT)) state_d = DROP;
                     end
                     2'd2: begin
`ifdef UDP_RX_LEN_CHECK_EN
                        len_d = field;
`endif
                        if (field < HDR_LEN) state_d = DROP;
                     end
                     default: begin
                        state_d = DATA;
                        pay_d   = '0;
                     end
                  endcase
                  // a term inside the header is a runt or an empty datagram
                  if (term_i) state_d = IDLE;
               end
               DATA: begin
                  valid_o = 1'b1;
                  start_o = (pay_q == '0);
                  term_o  = term_i;
                  pay_d   = pay_sum;
`ifdef UDP_RX_LEN_CHECK_EN
                  if (term_i && (pay_sum != (len_q - HDR_LEN))) cancel_o = 1'b1;
`endif
                  if (term_i) state_d = IDLE;
               end
               DROP: begin
                  if (term_i) state_d = IDLE;
               end
               default: begin
               end
            endcase
         end
      end

      // upstream abort overrides everything else
      if (cancel_i) begin
         state_d  = IDLE;
         cancel_o = cancel_o | (state_q == DATA);
      end
   end

endmodule

// File: tb/tb_udp_rx.sv
// tb_udp_rx: directed bench for udp_rx with hand-computed expectations.
// Observed output vector o = {valid_o, start_o, term_o, cancel_o}.
module tb_udp_rx;

   logic        clk = 1'b0;
   logic        nreset;
   logic        cancel_i, valid_i, start_i, term_i, cs_err_i;
   logic [15:0] data_i;
   logic [1:0]  len_i;
   logic        valid_o, start_o, term_o, cancel_o;
   logic [15:0] data_o;
   logic [1:0]  len_o;
   logic [15:0] src_port_o;

   int checks = 0;
   int errors = 0;

   logic [3:0]  o;
   logic [15:0] od;
   logic [1:0]  ol;
   logic [3:0]  acc;

   udp_rx dut (
      .clk(clk), .nreset(nreset), .cancel_i(cancel_i), .valid_i(valid_i),
      .start_i(start_i), .term_i(term_i), .data_i(data_i), .len_i(len_i),
      .cs_err_i(cs_err_i), .valid_o(valid_o), .start_o(start_o),
      .term_o(term_o), .cancel_o(cancel_o), .data_o(data_o), .len_o(len_o),
      .src_port_o(src_port_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] hw(input logic [15:0] f);
      return {f[7:0], f[15:8]};
   endfunction

   // one clock: drive inputs after the edge, sample outputs mid-cycle
   task automatic cyc(input logic v, input logic st, input logic tm, input logic [15:0] d,
                      input logic [1:0] ln, input logic ce, input logic cn);
      valid_i = v; start_i = st; term_i = tm; data_i = d; len_i = ln;
      cs_err_i = ce; cancel_i = cn;
      #2;
      o  = {valid_o, start_o, term_o, cancel_o};
      od = data_o;
      ol = len_o;
      @(posedge clk);
      #1;
   endtask

   // four header words; OR of outputs (and of gap cycles) collected in acc
   task automatic hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                      input logic ce, input logic tm3, input logic gap);
      logic [15:0] w [4];
      w[0] = src; w[1] = dst; w[2] = len; w[3] = 16'h0000;
      acc = '0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, i == 0, (i == 3) && tm3, hw(w[i]), 2'd2, ce && (i == 0), 1'b0);
         acc |= o;
         if (gap) begin
            cyc(1'b0, 1'b0, 1'b0, 16'hFFFF, 2'd2, 1'b0, 1'b0);
            acc |= o;
         end
      end
   endtask

   initial begin
      nreset = 1'b0;
      valid_i = 0; start_i = 0; term_i = 0; data_i = '0; len_i = '0;
      cs_err_i = 0; cancel_i = 0;
      repeat (2) @(posedge clk);
      #1;
      cyc(1'b0, 0, 0, 16'h0, 2'd0, 0, 0);
      check("reset_out", o, 4'b0000);
      check("reset_src", src_port_o, 16'h0000);
      nreset = 1'b1;

      // 1: normal datagram, 4-byte payload
      hdr(16'h1234, 16'd18, 16'd12, 0, 0, 0);
      check("t1_hdr_quiet", acc, 4'b0000);
      check("t1_src", src_port_o, 16'h1234);
      cyc(1, 0, 0, 16'hAABB, 2'd2, 0, 0);
      check("t1_w0", o, 4'b1100);
      check("t1_w0_data", od, 16'hAABB);
      check("t1_w0_len", ol, 2'd2);
      cyc(1, 0, 1, 16'hCCDD, 2'd2, 0, 0);
      check("t1_w1", o, 4'b1010);
      check("t1_w1_data", od, 16'hCCDD);

      // 2: wrong port dropped, next good one forwarded
      hdr(16'h0001, 16'd19, 16'd12, 0, 0, 0);
      cyc(1, 0, 0, 16'h1111, 2'd2, 0, 0); acc |= o;
      cyc(1, 0, 1, 16'h2222, 2'd2, 0, 0); acc |= o;
      check("t2_port_drop", acc, 4'b0000);
      hdr(16'h0002, 16'd18, 16'd12, 0, 0, 0);
      check("t2_src", src_port_o, 16'h0002);
      cyc(1, 0, 0, 16'h3333, 2'd2, 0, 0);
      check("t2_w0", o, 4'b1100);
      cyc(1, 0, 1, 16'h4444, 2'd2, 0, 0);
      check("t2_w1", o, 4'b1010);

      // 3: checksum error dropped; zero-length datagram; stray word in IDLE
      hdr(16'h0003, 16'd18, 16'd12, 1, 0, 0);
      cyc(1, 0, 0, 16'h5555, 2'd2, 0, 0); acc |= o;
      cyc(1, 0, 1, 16'h6666, 2'd2, 0, 0); acc |= o;
      check("t3_cserr_drop", acc, 4'b0000);
      hdr(16'h0004, 16'd18, 16'd8, 0, 1, 0);
      check("t3_len8_quiet", acc, 4'b0000);
      cyc(1, 0, 0, 16'h7777, 2'd2, 0, 0);
      check("t3_idle_after", o, 4'b0000);

      // length below header size dropped
      hdr(16'h0005, 16'd18, 16'd6, 0, 0, 0);
      cyc(1, 0, 1, 16'h8888, 2'd2, 0, 0); acc |= o;
      check("t3_short_drop", acc, 4'b0000);

      // runt: term on header word 2
      cyc(1, 1, 0, hw(16'h0006), 2'd2, 0, 0);
      cyc(1, 0, 0, hw(16'd18), 2'd2, 0, 0);
      cyc(1, 0, 1, hw(16'd12), 2'd2, 0, 0);
      cyc(1, 0, 0, 16'h9999, 2'd2, 0, 0);
      check("runt_idle", o, 4'b0000);

      // 4: upstream cancel on second payload word
      hdr(16'h0007, 16'd18, 16'd12, 0, 0, 0);
      cyc(1, 0, 0, 16'hA1A1, 2'd2, 0, 0);
      check("t4_w0", o, 4'b1100);
      cyc(1, 0, 0, 16'hA2A2, 2'd2, 0, 1);
      check("t4_cancel", o[0], 1'b1);
      cyc(1, 0, 0, 16'hA3A3, 2'd2, 0, 0);
      check("t4_idle_after", o, 4'b0000);
      hdr(16'h0008, 16'd18, 16'd12, 0, 0, 0);
      cyc(1, 0, 0, 16'hB1B1, 2'd2, 0, 0);
      check("t4_next_w0", o, 4'b1100);
      cyc(1, 0, 1, 16'hB2B2, 2'd2, 0, 0);
      check("t4_next_w1", o, 4'b1010);

      // start inside DATA aborts old payload and reparses
      hdr(16'h0009, 16'd18, 16'd12, 0, 0, 0);
      cyc(1, 0, 0, 16'hC1C1, 2'd2, 0, 0);
      cyc(1, 1, 0, hw(16'h000A), 2'd2, 0, 0);
      check("restart_cancel", o, 4'b0001);
      cyc(1, 0, 0, hw(16'd18), 2'd2, 0, 0);
      cyc(1, 0, 0, hw(16'd12), 2'd2, 0, 0);
      cyc(1, 0, 0, 16'h0000, 2'd2, 0, 0);
      check("restart_src", src_port_o, 16'h000A);
      cyc(1, 0, 0, 16'hC2C2, 2'd2, 0, 0);
      check("restart_w0", o, 4'b1100);
      cyc(1, 0, 1, 16'hC3C3, 2'd2, 0, 0);
      check("restart_w1", o, 4'b1010);

      // 5: odd lengths; len=13 consistent, len=15 short by two bytes
      hdr(16'h000B, 16'd18, 16'd13, 0, 0, 0);
      cyc(1, 0, 0, 16'hD1D1, 2'd2, 0, 0);
      cyc(1, 0, 0, 16'hD2D2, 2'd2, 0, 0);
      cyc(1, 0, 1, 16'h00D3, 2'd1, 0, 0);
      check("t5_len13_last", o, 4'b1010);
      check("t5_len13_len", ol, 2'd1);
      hdr(16'h000C, 16'd18, 16'd15, 0, 0, 0);
      cyc(1, 0, 0, 16'hE1E1, 2'd2, 0, 0);
      cyc(1, 0, 0, 16'hE2E2, 2'd2, 0, 0);
      cyc(1, 0, 1, 16'h00E3, 2'd1, 0, 0);
`ifdef UDP_RX_LEN_CHECK_EN
      check("t5_len15_last", o, 4'b1011);
`else
      check("t5_len15_last", o, 4'b1010);
`endif

      // 6: gaps between every header and payload word
      hdr(16'h000D, 16'd18, 16'd12, 0, 0, 1);
      check("t6_gap_hdr", acc, 4'b0000);
      cyc(1, 0, 0, 16'hF1F1, 2'd2, 0, 0);
      check("t6_gap_w0", o, 4'b1100);
      cyc(0, 0, 0, 16'hFFFF, 2'd2, 0, 0);
      check("t6_gap_idle", o, 4'b0000);
      cyc(1, 0, 1, 16'hF2F2, 2'd2, 0, 0);
      check("t6_gap_w1", o, 4'b1010);
      check("t6_gap_data", od, 16'hF2F2);

      // reset in the middle of a payload
      hdr(16'h000E, 16'd18, 16'd12, 0, 0, 0);
      cyc(1, 0, 0, 16'h1212, 2'd2, 0, 0);
      check("t6_pre_rst", o, 4'b1100);
      nreset = 1'b0;
      cyc(0, 0, 0, 16'h0, 2'd2, 0, 0);
      cyc(1, 0, 0, 16'h3434, 2'd2, 0, 0);
      check("t6_in_rst", o, 4'b0000);
      nreset = 1'b1;
      cyc(1, 0, 1, 16'h5656, 2'd2, 0, 0);
      check("t6_post_rst", o, 4'b0000);
      check("t6_post_src", src_port_o, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
